// File: rtl/alu_pkg.sv
// Shared opcodes and FSM state encoding for the sequential ALU.
package alu_pkg;

   localparam logic [2:0] OP_ADD = 3'd0;
   localparam logic [2:0] OP_SUB = 3'd1;
   localparam logic [2:0] OP_AND = 3'd2;
   localparam logic [2:0] OP_OR  = 3'd3;
   localparam logic [2:0] OP_XOR = 3'd4;
   localparam logic [2:0] OP_SLL = 3'd5;
   localparam logic [2:0] OP_SRL = 3'd6;
   localparam logic [2:0] OP_MUL = 3'd7;

   typedef enum logic [1:0] {
      IDLE,
      ITER,
      FIN
   } state_t;

endpackage

// File: rtl/alu_iter_unit.sv
// Shared iterative datapath: one-bit shifts and shift-add multiply.
// The multiplier path exists only when ALU_SEQ_MUL_EN is defined.
module alu_iter_unit
   import alu_pkg::*;
#(
   parameter int W  = 8,
   parameter int CW = $clog2(W + 1)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          load,
   input  logic          step,
   input  logic [2:0]    op,
   input  logic [W-1:0]  a,
   input  logic [W-1:0]  b,
   input  logic [CW-1:0] count,
   output logic [W-1:0]  res,
   output logic          carry,
   output logic          cnt_zero
);

   logic [2:0]    op_q;
   logic [W-1:0]  lo, lo_n;
   logic          cout, cout_n;
   logic [CW-1:0] cnt, cnt_n;
`ifdef ALU_SEQ_MUL_EN
   logic [W-1:0]  hi, hi_n, mcand;
   logic [W:0]    psum;
`else
   logic          unused_b;
   assign unused_b = ^b;
`endif

   assign cnt_n    = cnt - CW'(1);
   assign cnt_zero = (cnt_n == '0);
   assign res      = lo_n;

   // Next-step values are exported so the last step's result is usable at once
   always_comb begin
      lo_n   = lo;
      cout_n = cout;
`ifdef ALU_SEQ_MUL_EN
      hi_n = hi;
      psum = {1'b0, hi} + (lo[0] ? {1'b0, mcand} : '0);
`endif
      case (op_q)
         OP_SLL: begin
            cout_n = lo[W-1];
            lo_n   = {lo[W-2:0], 1'b0};
         end
         OP_SRL: begin
            cout_n = lo[0];
            lo_n   = {1'b0, lo[W-1:1]};
         end
`ifdef ALU_SEQ_MUL_EN
         OP_MUL: {hi_n, lo_n} = {psum, lo[W-1:1]};
`endif
         default: ;
      endcase
   end

`ifdef ALU_SEQ_MUL_EN
   assign carry = (op_q == OP_MUL) ? |hi_n : cout_n;
`else
   assign carry = cout_n;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         op_q <= OP_ADD;
         lo   <= '0;
         cout <= 1'b0;
         cnt  <= '0;
`ifdef ALU_SEQ_MUL_EN
         hi    <= '0;
         mcand <= '0;
`endif
      end else if (load) begin
         op_q <= op;
         cnt  <= count;
         cout <= 1'b0;
`ifdef ALU_SEQ_MUL_EN
         lo    <= (op == OP_MUL) ? b : a;
         hi    <= '0;
         mcand <= a;
`else
         lo <= a;
`endif
      end else if (step) begin
         lo   <= lo_n;
         cout <= cout_n;
         cnt  <= cnt_n;
`ifdef ALU_SEQ_MUL_EN
         hi <= hi_n;
`endif
      end
   end

endmodule

// File: rtl/alu_seq.sv
// Multi-cycle ALU with Start/Ready/Done handshake and registered flags.
// Define ALU_SEQ_MUL_EN to build the iterative multiplier for OP 7.
module alu_seq
   import alu_pkg::*;
#(
   parameter  int W  = 8,
   localparam int SW = $clog2(W)
) (
   input  logic         Clk,
   input  logic         Reset,
   input  logic         Start,
   input  logic [W-1:0] InputA,
   input  logic [W-1:0] InputB,
   input  logic [2:0]   OP,
   output logic         Ready,
   output logic         Done,
   output logic [W-1:0] Out,
   output logic         Zero,
   output logic         LT,
   output logic         Carry
);

   localparam int CW = $clog2(W + 1);
   localparam logic [W-1:0] W_VAL = W'(W);

   state_t        state;
   logic          accept, is_iter, lt_in, lt_q;
   logic          single_c, iter_c, iter_zero;
   logic [W-1:0]  single_res, iter_res;
   logic [W:0]    sum, diff;
   logic [CW-1:0] load_cnt;

   assign accept = Start & Ready;

   always_comb begin
      sum        = {1'b0, InputA} + {1'b0, InputB};
      diff       = {1'b0, InputA} - {1'b0, InputB};
      lt_in      = InputA < InputB;
      single_res = '0;
      single_c   = 1'b0;
      is_iter    = 1'b0;
      load_cnt   = CW'(InputB[SW-1:0]);
      case (OP)
         OP_ADD: begin
            single_res = sum[W-1:0];
            single_c   = sum[W];
         end
         OP_SUB: begin
            single_res = diff[W-1:0];
            single_c   = diff[W];
         end
         OP_AND: single_res = InputA & InputB;
         OP_OR:  single_res = InputA | InputB;
         OP_XOR: single_res = InputA ^ InputB;
         // Zero and out-of-range shift amounts finish without iterating
         OP_SLL, OP_SRL: begin
            if (InputB == '0) single_res = InputA;
            else if (InputB < W_VAL) is_iter = 1'b1;
         end
         OP_MUL: begin
`ifdef ALU_SEQ_MUL_EN
            is_iter  = 1'b1;
            load_cnt = CW'(W);
`endif
         end
         default: ;
      endcase
   end

   alu_iter_unit #(
      .W  (W),
      .CW (CW)
   ) u_iter (
      .clk      (Clk),
      .rst      (Reset),
      .load     (accept & is_iter),
      .step     (state == ITER),
      .op       (OP),
      .a        (InputA),
      .b        (InputB),
      .count    (load_cnt),
      .res      (iter_res),
      .carry    (iter_c),
      .cnt_zero (iter_zero)
   );

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state <= IDLE;
         Ready <= 1'b1;
         Done  <= 1'b0;
         Out   <= '0;
         Zero  <= 1'b1;
         LT    <= 1'b0;
         Carry <= 1'b0;
         lt_q  <= 1'b0;
      end else begin
         Done <= 1'b0;
         case (state)
            IDLE, FIN: begin
               if (Start) begin
                  lt_q <= lt_in;
                  if (is_iter) begin
                     state <= ITER;
                     Ready <= 1'b0;
                  end else begin
                     state <= FIN;
                     Ready <= 1'b1;
                     Done  <= 1'b1;
                     Out   <= single_res;
                     Zero  <= (single_res == '0);
                     LT    <= lt_in;
                     Carry <= single_c;
                  end
               end else begin
                  state <= IDLE;
                  Ready <= 1'b1;
               end
            end
            ITER: begin
               if (iter_zero) begin
                  state <= FIN;
                  Ready <= 1'b1;
                  Done  <= 1'b1;
                  Out   <= iter_res;
                  Zero  <= (iter_res == '0);
                  LT    <= lt_q;
                  Carry <= iter_c;
               end
            end
            default: begin
               state <= IDLE;
               Ready <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq at W=8 with a per-cycle reference model.
module tb_alu_seq;
   import alu_pkg::*;

   logic       Clk, Reset, Start;
   logic [7:0] InputA, InputB;
   logic [2:0] OP;
   logic       Ready, Done, Zero, LT, Carry;
   logic [7:0] Out;

   typedef struct {
      int         due;
      logic [7:0] out;
      logic       z;
      logic       lt;
      logic       c;
   } exp_t;

   exp_t q[$];
   exp_t hold;
   int   cyc = 0;
   int   total = 0;
   int   bad = 0;
   int   rdy_lo = -10;
   int   rdy_hi = -10;
   int   last_due = 0;
   bit   chk_en = 0;

   alu_seq #(.W(8)) dut (
      .Clk    (Clk),
      .Reset  (Reset),
      .Start  (Start),
      .InputA (InputA),
      .InputB (InputB),
      .OP     (OP),
      .Ready  (Ready),
      .Done   (Done),
      .Out    (Out),
      .Zero   (Zero),
      .LT     (LT),
      .Carry  (Carry)
   );

   initial Clk = 0;
   always #5 Clk = ~Clk;
   always @(posedge Clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s at cycle %0d: got=%0h want=%0h",
                  name, cyc, act, exp);
      end
   endtask

   // Reference behaviour from the arithmetic rules, independent of FSM detail
   function automatic void model(input logic [2:0] op,
                                 input logic [7:0] a, b,
                                 output logic [7:0] o,
                                 output logic c, output int lat);
      int unsigned ua, ub, r;
      ua = a; ub = b; r = 0; c = 0; lat = 1;
      case (op)
         OP_ADD: begin r = ua + ub; c = (r > 255); end
         OP_SUB: begin r = ua - ub; c = (ua < ub); end
         OP_AND: r = ua & ub;
         OP_OR:  r = ua | ub;
         OP_XOR: r = ua ^ ub;
         OP_SLL: begin
            if (ub == 0) r = ua;
            else if (ub < 8) begin
               r = ua << ub; c = r[8]; lat = 1 + int'(ub);
            end
         end
         OP_SRL: begin
            if (ub == 0) r = ua;
            else if (ub < 8) begin
               r = ua >> ub; c = ((ua >> (ub - 1)) & 1) != 0;
               lat = 1 + int'(ub);
            end
         end
         default: begin
`ifdef ALU_SEQ_MUL_EN
            r = ua * ub; c = (r >> 8) != 0; lat = 9;
`endif
         end
      endcase
      o = r[7:0];
   endfunction

   always @(negedge Clk) begin
      if (chk_en) begin
         bit exp_done;
         exp_done = (q.size() > 0 && q[0].due == cyc);
         if (exp_done) hold = q.pop_front();
         chk("done", Done, exp_done);
         chk("ready", Ready, !(cyc >= rdy_lo && cyc <= rdy_hi));
         chk("out", Out, hold.out);
         chk("zero", Zero, hold.z);
         chk("lt", LT, hold.lt);
         chk("carry", Carry, hold.c);
      end
   end

   task automatic issue(input logic [2:0] op, input logic [7:0] a, b,
                        input logic [7:0] lit_out, input logic lit_c,
                        input int lit_lat, input bit keep = 0);
      logic [7:0] o;
      logic       c;
      int         lat;
      exp_t       e;
      model(op, a, b, o, c, lat);
      chk("model_out", o, lit_out);
      chk("model_carry", c, lit_c);
      chk("model_lat", lat, lit_lat);
      e.due = cyc + lat; e.out = o; e.z = (o == 0);
      e.lt = (a < b); e.c = c;
      q.push_back(e);
      last_due = e.due;
      if (lat > 1) begin
         rdy_lo = cyc + 1;
         rdy_hi = cyc + lat - 1;
      end
      Start = 1; OP = op; InputA = a; InputB = b;
      @(posedge Clk); #2;
      if (!keep) Start = 0;
   endtask

   task automatic wait_done();
      while (cyc < last_due) begin
         @(posedge Clk); #2;
      end
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge Clk); #2;
      end
   endtask

   task automatic chk_reset_state(input string tag);
      chk({tag, "_done"}, Done, 0);
      chk({tag, "_ready"}, Ready, 1);
      chk({tag, "_out"}, Out, 0);
      chk({tag, "_zero"}, Zero, 1);
      chk({tag, "_lt"}, LT, 0);
      chk({tag, "_carry"}, Carry, 0);
   endtask

   task automatic rearm();
      hold = '{due: 0, out: 8'h00, z: 1'b1, lt: 1'b0, c: 1'b0};
      rdy_lo = -10;
      rdy_hi = -10;
      chk_en = 1;
   endtask

   initial begin
      Reset = 1; Start = 0; OP = OP_ADD; InputA = 0; InputB = 0;
      idle(2);
      Reset = 0;
      @(negedge Clk);
      chk_reset_state("rst");
      rearm();
      idle(1);

      issue(OP_ADD, 8'd200, 8'd100, 8'd44, 1, 1); wait_done();
      issue(OP_SUB, 8'd5, 8'd5, 8'd0, 0, 1); wait_done();
      issue(OP_SUB, 8'd3, 8'd9, 8'd250, 1, 1); wait_done();
      idle(2);
      issue(OP_SLL, 8'h81, 8'd3, 8'h08, 0, 4); wait_done();
      issue(OP_SRL, 8'h81, 8'd1, 8'h40, 1, 2); wait_done();
      issue(OP_SLL, 8'h81, 8'd9, 8'h00, 0, 1); wait_done();
      issue(OP_SLL, 8'h81, 8'd0, 8'h81, 0, 1); wait_done();
      issue(OP_SRL, 8'h80, 8'd7, 8'h01, 0, 8); wait_done();
      issue(OP_AND, 8'hF0, 8'h3C, 8'h30, 0, 1);
      issue(OP_OR, 8'hF0, 8'h3C, 8'hFC, 0, 1);
      issue(OP_XOR, 8'hF0, 8'h3C, 8'hCC, 0, 1);
      issue(OP_ADD, 8'hFF, 8'h01, 8'h00, 1, 1); wait_done();
      idle(1);
`ifdef ALU_SEQ_MUL_EN
      issue(OP_MUL, 8'd20, 8'd13, 8'd4, 1, 9); wait_done();
      issue(OP_MUL, 8'd7, 8'd6, 8'd42, 0, 9); wait_done();
      issue(OP_MUL, 8'd255, 8'd255, 8'd1, 1, 9); wait_done();
      issue(OP_MUL, 8'd20, 8'd13, 8'd4, 1, 9, 1);
`else
      issue(OP_MUL, 8'd20, 8'd13, 8'd0, 0, 1); wait_done();
      issue(OP_MUL, 8'd7, 8'd6, 8'd0, 0, 1); wait_done();
      issue(OP_SRL, 8'h80, 8'd7, 8'h01, 0, 8, 1);
`endif
      // Start stays high with a new request; it must wait for FIN
      OP = OP_ADD; InputA = 8'd1; InputB = 8'd1;
      wait_done();
      issue(OP_ADD, 8'd1, 8'd1, 8'd2, 0, 1); wait_done();
      idle(1);

`ifdef ALU_SEQ_MUL_EN
      issue(OP_MUL, 8'd3, 8'd200, 8'h58, 1, 9);
`else
      issue(OP_SRL, 8'h80, 8'd7, 8'h01, 0, 8);
`endif
      idle(2);
      chk_en = 0;
      q.delete();
      Reset = 1;
      idle(1);
      Reset = 0;
      @(negedge Clk);
      chk_reset_state("midrst");
      rearm();
      idle(12);
      issue(OP_XOR, 8'h0F, 8'hFF, 8'hF0, 0, 1); wait_done();
      idle(2);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got=timeout want=finish");
      $fatal(1, "watchdog");
   end

endmodule
